aes_spi_slave_if: RTL and testbench
===================================

Name: aes_spi_slave_if

Overview:
- SPI-style slave end of the host-to-crypto link, instantiated in front of each AES core (encrypt and decrypt).
- Deserialises the {message, key} frame shifted in on Mosi while cs is low, then hands it to the AES core with a start pulse.
- Waits for the core to finish, then serialises the 128-bit result back on Miso, framed by data_done.
- The master samples Miso while data_done=1 and releases cs on the falling edge of data_done.

Parameters:
- nk, 8, key length in 32-bit words (key width KEY_W = 32*nk).
- nb, 4, block length in 32-bit words (message/result width MSG_W = 32*nb).
- nr, 14, round count; passed through for core configuration only, no effect on this block's logic.

Ports:
- in_clk  input  1  serial/system clock (the master's out_clk); all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- cs  input  1  chip select, active low.
- Mosi  input  1  serial data from master, MSB first.
- Miso  output  1  serial result to master, MSB first.
- data_done  output  1  high exactly while the MSG_W result bits are valid on Miso.
- core_msg  output  MSG_W  captured message to the AES core.
- core_key  output  KEY_W  captured key to the AES core.
- core_start  output  1  one-cycle pulse; core_msg/core_key are valid from this cycle on.
- core_result  input  MSG_W  AES core output block.
- core_done  input  1  one-cycle pulse; core_result is valid in the same cycle.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; Miso=0, data_done=0, core_start=0, busy=0; core_msg=0, core_key=0; bit counter=0; shift registers cleared.
- Frame: FRAME_W = MSG_W + KEY_W = 384 bits, message bits first, each field MSB first. Bit counter is 9 bits wide and counts 0..FRAME_W-1.
- IDLE:
  - cs=0 moves to RX on that edge, with no sample taken.
  - cs=1: hold.
- RX:
  - Each rising edge with cs=0: shift Mosi into the LSB of the frame register; counter+1.
  - On the edge that takes bit FRAME_W-1:
    - load core_msg = frame[383:256], core_key = frame[255:0], including the current bit;
    - pulse core_start=1 for exactly one cycle;
    - go to WAIT.
  - cs=1 mid-frame aborts: counter=0, partial frame discarded, core outputs unchanged, go to IDLE, no start pulse.
- WAIT:
  - core_done=1 latches core_result into the tx shift register; go to TX.
  - core_done is ignored in every other state, including the cycle core_start is asserted.
  - cs changes are ignored.
- TX:
  - First TX cycle: data_done=1, Miso=result[127].
  - Each following edge shifts left by one: Miso=next bit.
  - data_done stays 1 for exactly MSG_W=128 consecutive cycles.
  - On the edge after the last bit: data_done=0, Miso=0, go to DONE.
  - Registered outputs: the master sees bit i at the posedge following the one that drove it.
- DONE:
  - Wait for cs=1, then go to IDLE.
  - cs still 0 in DONE: hold and do not start a new frame. A new frame needs cs to go high and then low again.
- Reset mid-operation (any state): immediate return to reset values. A pending core_done after reset is ignored.
- core_msg/core_key keep their values until the next complete frame.
- Latency: core_start fires at the edge that takes the 384th bit. The first result bit is on Miso one cycle after core_done.

Decomposition:
- Package aes_spi_pkg:
  - MSG_W, KEY_W, FRAME_W, CNT_W=$clog2(FRAME_W) derived from nb/nk;
  - state enum {IDLE, RX, WAIT, TX, DONE}.
- One natural sub-module, aes_spi_tx_shifter: MSG_W-bit parallel-load, MSB-first shift register with 8-bit counter. It owns Miso and data_done generation. The top block keeps the FSM and the RX frame register.

Test Plan:
- Nominal encrypt:
  - Shift msg=00112233445566778899aabbccddeeff and key=000102…1e1f (384 bits).
  - Required: core_msg/core_key equal those values, with a single core_start pulse on the 384th sample edge.
  - Model core_done 20 cycles later with result 8ea2b7ca516745bfeafc49904b496089.
  - Required: data_done high for 128 cycles and Miso stream equal to 8ea2b7ca….
- Abort: raise cs after 100 bits. Required: state IDLE, no core_start, core_msg/core_key unchanged. A following full frame is captured correctly.
- Reset mid-TX: assert rst=0 at result bit 50. Required: data_done=0, Miso=0, busy=0 immediately. A later stray core_done pulse produces no output.
- Spurious done: pulse core_done during RX and in the core_start cycle. Required: ignored. Only the WAIT-state pulse is latched.
- Back-to-back frames:
  - Keep cs low after data_done falls. Required: no new capture.
  - Then raise and lower cs and send a second frame. Required: second core_start occurs and the result is returned correctly.
- Exact framing: count cycles with data_done=1. Required: 128. Check that Miso=0 whenever data_done=0.

Source files
------------

// File: rtl/aes_spi_pkg.sv
// Shared widths and FSM state type for the AES SPI slave link.
package aes_spi_pkg;

   localparam int unsigned NK      = 8;
   localparam int unsigned NB      = 4;
   localparam int unsigned NR      = 14;
   localparam int unsigned MSG_W   = 32 * NB;
   localparam int unsigned KEY_W   = 32 * NK;
   localparam int unsigned FRAME_W = MSG_W + KEY_W;
   localparam int unsigned CNT_W   = $clog2(FRAME_W);

   typedef enum logic [2:0] {
      IDLE,
      RX,
      WAIT,
      TX,
      DONE
   } state_e;

endpackage

// File: rtl/aes_spi_tx_shifter.sv
// MSB-first result serialiser: owns Miso and the data_done framing window.
module aes_spi_tx_shifter #(
   parameter int unsigned MSG_W = 128
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [MSG_W-1:0] data_i,
   output logic             miso_o,
   output logic             data_done_o,
   output logic             last_o
);

   localparam logic [7:0] LAST = 8'(MSG_W - 1);

   logic [MSG_W-1:0] sh_q;
   logic [7:0]       cnt_q;
   logic             dd_q;

   // Load the result, then shift once per edge; the final shift drains the
   // register to zero so Miso is 0 whenever data_done is low.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sh_q  <= '0;
         cnt_q <= '0;
         dd_q  <= 1'b0;
      end else if (load_i) begin
         sh_q  <= data_i;
         cnt_q <= '0;
         dd_q  <= 1'b1;
      end else if (dd_q) begin
         sh_q <= {sh_q[MSG_W-2:0], 1'b0};
         if (cnt_q == LAST) begin
            cnt_q <= '0;
            dd_q  <= 1'b0;
         end else begin
            cnt_q <= cnt_q + 8'd1;
         end
      end
   end

   assign miso_o      = sh_q[MSG_W-1];
   assign data_done_o = dd_q;
   assign last_o      = dd_q && (cnt_q == LAST);

endmodule

// File: rtl/aes_spi_slave_if.sv
// SPI slave front end of an AES core: frame capture, core handshake, result return.
module aes_spi_slave_if
   import aes_spi_pkg::*;
#(
   parameter int unsigned nk = NK,
   parameter int unsigned nb = NB,
   parameter int unsigned nr = NR
) (
   input  logic              in_clk,
   input  logic              rst,
   input  logic              cs,
   input  logic              Mosi,
   output logic              Miso,
   output logic              data_done,
   output logic [32*nb-1:0]  core_msg,
   output logic [32*nk-1:0]  core_key,
   output logic              core_start,
   input  logic [32*nb-1:0]  core_result,
   input  logic              core_done,
   output logic              busy
);

   localparam int unsigned MW = 32 * nb;
   localparam int unsigned KW = 32 * nk;
   localparam int unsigned FW = MW + KW;
   localparam int unsigned CW = $clog2(FW);

   // Round count only configures the core; reject values AES does not define.
   if (nr != 10 && nr != 12 && nr != 14) begin : g_nr_check
      $error("aes_spi_slave_if: unsupported round count nr");
   end

   state_e         state_q;
   logic [FW-2:0]  frame_q;
   logic [FW-1:0]  frame_d;
   logic [CW-1:0]  cnt_q;
   logic [MW-1:0]  msg_q;
   logic [KW-1:0]  key_q;
   logic           start_q;
   logic           busy_q;
   logic           tx_load;
   logic           tx_last;

   // The frame register holds one bit less than a frame: the last bit is
   // taken straight from Mosi on the capture edge.
   assign frame_d = {frame_q, Mosi};
   // A done coinciding with the start pulse belongs to no valid request.
   assign tx_load = (state_q == WAIT) && core_done && !start_q;

   // Link FSM with frame capture and registered handshake outputs.
   always_ff @(posedge in_clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         frame_q <= '0;
         cnt_q   <= '0;
         msg_q   <= '0;
         key_q   <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!cs) begin
                  state_q <= RX;
                  busy_q  <= 1'b1;
               end
            end
            RX: begin
               if (cs) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  frame_q <= '0;
                  busy_q  <= 1'b0;
               end else if (cnt_q == CW'(FW - 1)) begin
                  msg_q   <= frame_d[FW-1:KW];
                  key_q   <= frame_d[KW-1:0];
                  start_q <= 1'b1;
                  cnt_q   <= '0;
                  frame_q <= '0;
                  state_q <= WAIT;
               end else begin
                  frame_q <= frame_d[FW-2:0];
                  cnt_q   <= cnt_q + CW'(1);
               end
            end
            WAIT: begin
               if (tx_load) state_q <= TX;
            end
            TX: begin
               if (tx_last) state_q <= DONE;
            end
            DONE: begin
               if (cs) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   aes_spi_tx_shifter #(
      .MSG_W (MW)
   ) u_tx (
      .clk_i       (in_clk),
      .rst_ni      (rst),
      .load_i      (tx_load),
      .data_i      (core_result),
      .miso_o      (Miso),
      .data_done_o (data_done),
      .last_o      (tx_last)
   );

   assign core_msg   = msg_q;
   assign core_key   = key_q;
   assign core_start = start_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_aes_spi_slave_if.sv
// Self-checking bench for aes_spi_slave_if: timeline-based expectation model.
module tb_aes_spi_slave_if;

   logic         clk = 1'b0;
   logic         rst;
   logic         cs;
   logic         Mosi;
   logic         Miso;
   logic         data_done;
   logic [127:0] core_msg;
   logic [255:0] core_key;
   logic         core_start;
   logic [127:0] core_result;
   logic         core_done;
   logic         busy;

   int           checks = 0;
   int           errors = 0;

   logic         chk_en = 1'b0;
   logic         exp_busy, exp_start, exp_dd, exp_miso;
   logic [127:0] exp_msg;
   logic [255:0] exp_key;
   int           dd_cnt = 0;
   logic [127:0] stream = '0;

   localparam logic [127:0] NOM_MSG = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] NOM_KEY =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] NOM_RES = 128'h8ea2b7ca516745bfeafc49904b496089;

   aes_spi_slave_if #(
      .nk (8),
      .nb (4),
      .nr (14)
   ) dut (
      .in_clk      (clk),
      .rst         (rst),
      .cs          (cs),
      .Mosi        (Mosi),
      .Miso        (Miso),
      .data_done   (data_done),
      .core_msg    (core_msg),
      .core_key    (core_key),
      .core_start  (core_start),
      .core_result (core_result),
      .core_done   (core_done),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the expectation timeline.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy",       256'(busy),       256'(exp_busy));
         check("core_start", 256'(core_start), 256'(exp_start));
         check("data_done",  256'(data_done),  256'(exp_dd));
         check("Miso",       256'(Miso),       256'(exp_miso));
         check("core_msg",   256'(core_msg),   256'(exp_msg));
         check("core_key",   core_key,         exp_key);
         if (data_done === 1'b1) begin
            dd_cnt++;
            stream = {stream[126:0], Miso};
         end
      end
   end

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic set_exp(input logic b, input logic s, input logic d, input logic m);
      exp_busy  = b;
      exp_start = s;
      exp_dd    = d;
      exp_miso  = m;
   endtask

   // Apply inputs for the coming edge, then step to just after it.
   task automatic tick(input logic c, input logic m, input logic d, input logic [127:0] r);
      cs          = c;
      Mosi        = m;
      core_done   = d;
      core_result = r;
      @(posedge clk);
      #1;
      core_done = 1'b0;
   endtask

   // Select, then shift a {msg,key} frame; optional abort and stray core_done.
   task automatic rx_frame(input logic [127:0] msg, input logic [255:0] key,
                           input int abort_at, input int spur_rx);
      logic [383:0] f;
      f = {msg, key};
      tick(1'b0, 1'($urandom), 1'b0, rnd128());
      set_exp(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 384; i++) begin
         if (i == abort_at) begin
            tick(1'b1, 1'($urandom), 1'b0, rnd128());
            set_exp(1'b0, 1'b0, 1'b0, 1'b0);
            return;
         end
         tick(1'b0, f[383-i], (i == spur_rx), rnd128());
         if (i == 383) begin
            exp_msg = msg;
            exp_key = key;
            set_exp(1'b1, 1'b1, 1'b0, 1'b0);
         end else begin
            set_exp(1'b1, 1'b0, 1'b0, 1'b0);
         end
      end
   endtask

   // Core latency, result return, DONE hold with cs low, then release cs.
   // rst_bit >= 1 asserts reset while that result bit is on Miso and returns.
   task automatic tx_phase(input logic [127:0] res, input int wait_cyc, input logic spur_start,
                           input int rst_bit, input int hold);
      dd_cnt = 0;
      stream = '0;
      for (int w = 0; w < wait_cyc; w++) begin
         tick(1'($urandom), 1'($urandom), (w == 0) && spur_start, rnd128());
         set_exp(1'b1, 1'b0, 1'b0, 1'b0);
      end
      tick(1'($urandom), 1'($urandom), 1'b1, res);
      set_exp(1'b1, 1'b0, 1'b1, res[127]);
      for (int j = 1; j < 128; j++) begin
         tick(1'($urandom), 1'($urandom), 1'($urandom), rnd128());
         set_exp(1'b1, 1'b0, 1'b1, res[127-j]);
         if (j == rst_bit) begin
            rst     = 1'b0;
            exp_msg = '0;
            exp_key = '0;
            set_exp(1'b0, 1'b0, 1'b0, 1'b0);
            return;
         end
      end
      tick(1'b0, 1'($urandom), 1'b0, rnd128());
      set_exp(1'b1, 1'b0, 1'b0, 1'b0);
      check("dd_len", 256'(dd_cnt), 256'd128);
      check("stream", 256'(stream), 256'(res));
      for (int h = 0; h < hold; h++) begin
         tick(1'b0, 1'($urandom), 1'($urandom), rnd128());
         set_exp(1'b1, 1'b0, 1'b0, 1'b0);
      end
      tick(1'b1, 1'($urandom), 1'b0, rnd128());
      set_exp(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [127:0] m, r;
      logic [255:0] k;
      rst         = 1'b0;
      cs          = 1'b1;
      Mosi        = 1'b0;
      core_done   = 1'b0;
      core_result = '0;
      exp_msg     = '0;
      exp_key     = '0;
      set_exp(1'b0, 1'b0, 1'b0, 1'b0);
      chk_en      = 1'b1;

      // Reset state, including a core_done pulse while held in reset.
      tick(1'b1, 1'b0, 1'b0, '0);
      tick(1'b1, 1'b0, 1'b1, rnd128());
      tick(1'b1, 1'b0, 1'b0, '0);
      rst = 1'b1;
      tick(1'b1, 1'b0, 1'b0, '0);

      // Nominal encrypt vector with stray core_done in RX and in the start cycle.
      rx_frame(NOM_MSG, NOM_KEY, -1, 200);
      check("nom_msg", 256'(core_msg), 256'(128'h00112233445566778899aabbccddeeff));
      check("nom_key", core_key,
            256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
      tx_phase(NOM_RES, 20, 1'b1, -1, 0);
      check("nom_stream", 256'(stream), 256'(128'h8ea2b7ca516745bfeafc49904b496089));

      // Abort after 100 bits, then a full frame.
      rx_frame(rnd128(), {rnd128(), rnd128()}, 100, -1);
      check("abort_msg_kept", 256'(core_msg), 256'(NOM_MSG));
      tick(1'b1, 1'b0, 1'b0, '0);
      set_exp(1'b0, 1'b0, 1'b0, 1'b0);
      m = rnd128(); k = {rnd128(), rnd128()}; r = rnd128();
      rx_frame(m, k, -1, 383);
      tx_phase(r, 3, 1'b1, -1, 0);

      // cs kept low after data_done falls: no new capture until cs toggles.
      m = rnd128(); k = {rnd128(), rnd128()}; r = rnd128();
      rx_frame(m, k, -1, -1);
      tx_phase(r, 1, 1'b0, -1, 8);
      m = rnd128(); k = {rnd128(), rnd128()}; r = rnd128();
      rx_frame(m, k, -1, -1);
      tx_phase(r, 2, 1'b0, -1, 0);

      // Reset while result bit 50 is on the line, then a stray core_done.
      m = rnd128(); k = {rnd128(), rnd128()}; r = rnd128();
      rx_frame(m, k, -1, -1);
      tx_phase(r, 5, 1'b0, 50, 0);
      tick(1'b1, 1'b0, 1'b0, '0);
      set_exp(1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      tick(1'b1, 1'b0, 1'b1, rnd128());
      set_exp(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, '0);
      set_exp(1'b0, 1'b0, 1'b0, 1'b0);

      // Randomised frames with random aborts, latencies and hold times.
      for (int n = 0; n < 5; n++) begin
         m = rnd128(); k = {rnd128(), rnd128()}; r = rnd128();
         if ($urandom_range(0, 2) == 0) begin
            rx_frame(rnd128(), {rnd128(), rnd128()}, int'($urandom_range(0, 383)), -1);
            tick(1'b1, 1'b0, 1'b0, '0);
            set_exp(1'b0, 1'b0, 1'b0, 1'b0);
         end
         rx_frame(m, k, -1, int'($urandom_range(0, 383)));
         tx_phase(r, int'($urandom_range(1, 30)), 1'($urandom), -1, int'($urandom_range(0, 6)));
      end

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
